// File: rtl/dline_cache.sv
// Direct-mapped, write-through / write-allocate data cache with 64-byte lines.
// Single FSM serves one 64-bit request at a time through a line-wide arbiter port.
module dline_cache #(
    parameter int LINES = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         wenable,
    input  logic [63:0]  addr,
    input  logic [63:0]  wdata,
    output logic [63:0]  rdata,
    output logic         done,
    output logic         mreq,
    output logic         mwrenable,
    output logic [63:0]  maddr,
    input  logic [511:0] mrdata,
    output logic [511:0] mwdata,
    input  logic         mdone
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 58 - IW;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

    state_t             state;
    logic [LINES-1:0]   valid;
    logic [TW-1:0]      tags  [LINES];
    logic [511:0]       lines [LINES];

    logic               req_we;
    logic               req_mmio;
    logic [63:3]        req_addr;
    logic [63:0]        req_wdata;

    logic [IW-1:0]      in_idx;
    logic [TW-1:0]      in_tag;
    logic [2:0]         in_word;
    logic               in_mmio;
    logic               in_hit;
    logic [511:0]       in_line;
    logic [63:0]        hit_word;

    logic [IW-1:0]      rq_idx;
    logic [TW-1:0]      rq_tag;
    logic [2:0]         rq_word;
    logic [511:0]       fill_merge;
    logic [63:0]        fill_word;

    logic               arr_we;
    logic [IW-1:0]      arr_idx;
    logic [TW-1:0]      arr_tag;
    logic [511:0]       arr_line;

    function automatic logic [511:0] merge_word(input logic [511:0] line,
                                                input logic [63:0]  w,
                                                input logic [2:0]   sel);
        merge_word = line;
        merge_word[{sel, 6'b0} +: 64] = w;
    endfunction

    always_comb begin
        in_idx     = addr[6 +: IW];
        in_tag     = addr[63 -: TW];
        in_word    = addr[5:3];
        in_mmio    = (addr > 64'd655360) && (addr < 64'd1048576);
        in_hit     = !in_mmio && valid[in_idx] && (tags[in_idx] == in_tag);
        in_line    = lines[in_idx];
        hit_word   = in_line[{in_word, 6'b0} +: 64];
        rq_idx     = req_addr[6 +: IW];
        rq_tag     = req_addr[63 -: TW];
        rq_word    = req_addr[5:3];
        fill_merge = merge_word(mrdata, req_wdata, rq_word);
        fill_word  = mrdata[{rq_word, 6'b0} +: 64];
    end

    // A store miss installs the already-merged line, so WRITE never touches the array.
    always_comb begin
        arr_we   = 1'b0;
        arr_idx  = in_idx;
        arr_tag  = in_tag;
        arr_line = merge_word(in_line, wdata, in_word);
        if (state == IDLE && enable && wenable && in_hit) begin
            arr_we = 1'b1;
        end else if (state == FILL && mdone && !req_mmio) begin
            arr_we   = 1'b1;
            arr_idx  = rq_idx;
            arr_tag  = rq_tag;
            arr_line = req_we ? fill_merge : mrdata;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            lines[arr_idx] <= arr_line;
            tags[arr_idx]  <= arr_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= '0;
            done      <= 1'b0;
            mreq      <= 1'b0;
            mwrenable <= 1'b0;
            maddr     <= '0;
            mwdata    <= '0;
            rdata     <= '0;
            req_we    <= 1'b0;
            req_mmio  <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        req_we    <= wenable;
                        req_mmio  <= in_mmio;
                        req_addr  <= addr[63:3];
                        req_wdata <= wdata;
                        maddr     <= {addr[63:6], 6'b0};
                        if (in_hit && !wenable) begin
                            rdata <= hit_word;
                            done  <= 1'b1;
                            state <= RESP;
                        end else if (in_hit) begin
                            mreq      <= 1'b1;
                            mwrenable <= 1'b1;
                            mwdata    <= arr_line;
                            state     <= WRITE;
                        end else begin
                            mreq      <= 1'b1;
                            mwrenable <= 1'b0;
                            state     <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (mdone) begin
                        if (req_we) begin
                            mwrenable <= 1'b1;
                            mwdata    <= fill_merge;
                            state     <= WRITE;
                        end else begin
                            mreq  <= 1'b0;
                            rdata <= fill_word;
                            done  <= 1'b1;
                            state <= RESP;
                        end
                    end
                end
                WRITE: begin
                    if (mdone) begin
                        mreq      <= 1'b0;
                        mwrenable <= 1'b0;
                        rdata     <= req_wdata;
                        done      <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (arr_we) valid[arr_idx] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dline_cache.sv
// Directed bench for dline_cache: scripted line memory with programmable latency,
// per-scenario tasks with hand-computed expectations.
module tb_dline_cache;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         wenable = 1'b0;
    logic [63:0]  addr = '0;
    logic [63:0]  wdata = '0;
    logic [63:0]  rdata;
    logic         done;
    logic         mreq;
    logic         mwrenable;
    logic [63:0]  maddr;
    logic [511:0] mrdata;
    logic [511:0] mwdata;
    logic         mdone;

    int           vecs = 0;
    int           errs = 0;

    int           mem_lat = 0;
    int           cnt = 0;
    logic [511:0] fill_line = '0;

    int           done_cnt = 0;
    int           rd_txn = 0;
    int           wr_txn = 0;
    logic         prev_we = 1'b0;
    logic         last_we = 1'b0;
    logic [63:0]  last_maddr = '0;
    logic [511:0] last_mwdata = '0;

    dline_cache #(.LINES(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .wenable(wenable),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
        .mreq(mreq), .mwrenable(mwrenable), .maddr(maddr),
        .mrdata(mrdata), .mwdata(mwdata), .mdone(mdone)
    );

    always #5 clk = ~clk;

    // Arbiter model: mdone after mem_lat cycles of mreq (0 = same cycle).
    assign mdone  = mreq && (cnt == mem_lat);
    assign mrdata = fill_line;
    always @(posedge clk) begin
        if (!mreq || mdone) cnt <= 0;
        else cnt <= cnt + 1;
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mreq && mdone) begin
            if (mwrenable) wr_txn++;
            else rd_txn++;
            prev_we     = last_we;
            last_we     = mwrenable;
            last_maddr  = maddr;
            last_mwdata = mwdata;
        end
    end

    // Called on a negedge with the DUT idle; returns on a negedge after the done pulse.
    task automatic do_req(input logic we, input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] rd, output int lat);
        enable = 1'b1; wenable = we; addr = a; wdata = wd;
        @(negedge clk);
        enable = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            vecs++; errs++;
            $display("FAIL req_timeout: addr %h got no done, want done within 40 cycles", a);
        end
        rd = rdata;
        @(negedge clk);
    endtask

    function automatic logic [511:0] pattern(input logic [63:0] base);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k);
        return l;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", done); end
        vecs++; if (mreq !== 1'b0) begin errs++; $display("FAIL reset_mreq: got %b want 0", mreq); end
        vecs++; if (mwrenable !== 1'b0) begin errs++; $display("FAIL reset_mwrenable: got %b want 0", mwrenable); end
        vecs++; if (maddr !== 64'h0) begin errs++; $display("FAIL reset_maddr: got %h want 0", maddr); end
        vecs++; if (mwdata !== 512'h0) begin errs++; $display("FAIL reset_mwdata: got nonzero want 0"); end
        vecs++; if (rdata !== 64'h0) begin errs++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        reset = 1'b0;
    endtask

    task automatic test_cold_load;
        logic [63:0] rd;
        int lat, d0, r0, w0;
        mem_lat = 0;
        fill_line = pattern(64'h1000_0000_0000_0000);
        fill_line[127:64] = 64'hAABB;
        d0 = done_cnt; r0 = rd_txn; w0 = wr_txn;
        do_req(1'b0, 64'h1008, 64'h0, rd, lat);
        vecs++; if (rd !== 64'h0000_0000_0000_AABB) begin errs++; $display("FAIL cold_rdata: got %h want 000000000000aabb", rd); end
        vecs++; if (lat !== 2) begin errs++; $display("FAIL cold_latency: got %0d want 2", lat); end
        vecs++; if (rd_txn - r0 !== 1 || wr_txn - w0 !== 0) begin errs++; $display("FAIL cold_txn: got rd %0d wr %0d want rd 1 wr 0", rd_txn - r0, wr_txn - w0); end
        vecs++; if (last_maddr !== 64'h1000) begin errs++; $display("FAIL cold_maddr: got %h want 1000", last_maddr); end
        vecs++; if (done_cnt - d0 !== 1) begin errs++; $display("FAIL cold_done_pulses: got %0d want 1", done_cnt - d0); end
        r0 = rd_txn;
        do_req(1'b0, 64'h1008, 64'h0, rd, lat);
        vecs++; if (rd !== 64'hAABB) begin errs++; $display("FAIL hit_rdata: got %h want aabb", rd); end
        vecs++; if (lat !== 1) begin errs++; $display("FAIL hit_latency: got %0d want 1", lat); end
        vecs++; if (rd_txn - r0 !== 0) begin errs++; $display("FAIL hit_no_mreq: got %0d fills want 0", rd_txn - r0); end
    endtask

    task automatic test_store_hit;
        logic [63:0] rd;
        logic [511:0] exp;
        int lat, r0, w0;
        fill_line = '1;
        exp = pattern(64'h1000_0000_0000_0000);
        exp[127:64]  = 64'hAABB;
        exp[191:128] = 64'h55;
        r0 = rd_txn; w0 = wr_txn;
        do_req(1'b1, 64'h1010, 64'h55, rd, lat);
        vecs++; if (rd_txn - r0 !== 0 || wr_txn - w0 !== 1) begin errs++; $display("FAIL sthit_txn: got rd %0d wr %0d want rd 0 wr 1", rd_txn - r0, wr_txn - w0); end
        vecs++; if (last_mwdata !== exp) begin errs++; $display("FAIL sthit_mwdata: got %h want %h", last_mwdata, exp); end
        vecs++; if (last_maddr !== 64'h1000) begin errs++; $display("FAIL sthit_maddr: got %h want 1000", last_maddr); end
        vecs++; if (lat !== 2) begin errs++; $display("FAIL sthit_latency: got %0d want 2", lat); end
        vecs++; if (rd !== 64'h55) begin errs++; $display("FAIL sthit_rdata: got %h want 55", rd); end
        do_req(1'b0, 64'h1010, 64'h0, rd, lat);
        vecs++; if (rd !== 64'h55 || lat !== 1) begin errs++; $display("FAIL sthit_reload: got %h lat %0d want 55 lat 1", rd, lat); end
        do_req(1'b0, 64'h1008, 64'h0, rd, lat);
        vecs++; if (rd !== 64'hAABB || lat !== 1) begin errs++; $display("FAIL sthit_neighbor: got %h lat %0d want aabb lat 1", rd, lat); end
    endtask

    task automatic test_conflict;
        logic [63:0] rd;
        int lat, r0;
        mem_lat = 2;
        fill_line = '0;
        fill_line[63:0] = 64'hB0B0;
        r0 = rd_txn;
        do_req(1'b0, 64'h1200, 64'h0, rd, lat);
        vecs++; if (rd_txn - r0 !== 1 || last_maddr !== 64'h1200) begin errs++; $display("FAIL conflict_miss: got %0d fills maddr %h want 1 fill maddr 1200", rd_txn - r0, last_maddr); end
        vecs++; if (rd !== 64'hB0B0 || lat !== 4) begin errs++; $display("FAIL conflict_data: got %h lat %0d want b0b0 lat 4", rd, lat); end
        fill_line[63:0] = 64'hC0C0;
        r0 = rd_txn;
        do_req(1'b0, 64'h1000, 64'h0, rd, lat);
        vecs++; if (rd_txn - r0 !== 1 || rd !== 64'hC0C0) begin errs++; $display("FAIL conflict_evicted: got %0d fills data %h want 1 fill data c0c0", rd_txn - r0, rd); end
        r0 = rd_txn;
        do_req(1'b0, 64'h1000, 64'h0, rd, lat);
        vecs++; if (rd_txn - r0 !== 0 || rd !== 64'hC0C0 || lat !== 1) begin errs++; $display("FAIL conflict_rehit: got %0d fills data %h lat %0d want 0 c0c0 1", rd_txn - r0, rd, lat); end
        mem_lat = 0;
    endtask

    task automatic test_mmio;
        logic [63:0] rd;
        int lat, r0;
        fill_line = '0;
        fill_line[63:0]   = 64'hD0;
        fill_line[127:64] = 64'hD1;
        r0 = rd_txn;
        do_req(1'b0, 64'hA0008, 64'h0, rd, lat);
        vecs++; if (rd_txn - r0 !== 1 || last_maddr !== 64'hA0000 || rd !== 64'hD1) begin errs++; $display("FAIL mmio_first: got %0d fills maddr %h data %h want 1 a0000 d1", rd_txn - r0, last_maddr, rd); end
        r0 = rd_txn;
        do_req(1'b0, 64'hA0008, 64'h0, rd, lat);
        vecs++; if (rd_txn - r0 !== 1) begin errs++; $display("FAIL mmio_uncached: got %0d fills want 1", rd_txn - r0); end
        r0 = rd_txn;
        do_req(1'b0, 64'hA0000, 64'h0, rd, lat);
        vecs++; if (rd_txn - r0 !== 1 || rd !== 64'hD0) begin errs++; $display("FAIL edge_fill: got %0d fills data %h want 1 d0", rd_txn - r0, rd); end
        r0 = rd_txn;
        do_req(1'b0, 64'hA0000, 64'h0, rd, lat);
        vecs++; if (rd_txn - r0 !== 0 || lat !== 1 || rd !== 64'hD0) begin errs++; $display("FAIL edge_cached: got %0d fills lat %0d data %h want 0 1 d0", rd_txn - r0, lat, rd); end
        fill_line[127:64] = 64'hE1;
        r0 = rd_txn;
        do_req(1'b0, 64'hA0008, 64'h0, rd, lat);
        vecs++; if (rd_txn - r0 !== 1 || rd !== 64'hE1) begin errs++; $display("FAIL mmio_no_lookup: got %0d fills data %h want 1 e1", rd_txn - r0, rd); end
    endtask

    task automatic test_store_miss;
        logic [63:0] rd;
        logic [511:0] exp;
        int lat, d0, r0, w0;
        fill_line = pattern(64'h2000_0000_0000_0000);
        exp = pattern(64'h2000_0000_0000_0000);
        exp[63:0] = 64'h77;
        d0 = done_cnt; r0 = rd_txn; w0 = wr_txn;
        do_req(1'b1, 64'h2000, 64'h77, rd, lat);
        vecs++; if (rd_txn - r0 !== 1 || wr_txn - w0 !== 1) begin errs++; $display("FAIL stmiss_txn: got rd %0d wr %0d want 1 1", rd_txn - r0, wr_txn - w0); end
        vecs++; if (prev_we !== 1'b0 || last_we !== 1'b1) begin errs++; $display("FAIL stmiss_order: got %b%b want 01", prev_we, last_we); end
        vecs++; if (done_cnt - d0 !== 1) begin errs++; $display("FAIL stmiss_done: got %0d pulses want 1", done_cnt - d0); end
        vecs++; if (last_mwdata !== exp) begin errs++; $display("FAIL stmiss_mwdata: got %h want %h", last_mwdata, exp); end
        vecs++; if (lat !== 3 || rd !== 64'h77) begin errs++; $display("FAIL stmiss_resp: got lat %0d data %h want 3 77", lat, rd); end
        r0 = rd_txn;
        do_req(1'b0, 64'h2008, 64'h0, rd, lat);
        vecs++; if (rd_txn - r0 !== 0 || rd !== 64'h2000_0000_0000_0001) begin errs++; $display("FAIL stmiss_allocated: got %0d fills data %h want 0 2000000000000001", rd_txn - r0, rd); end
    endtask

    task automatic test_reset_mid_fill;
        logic [63:0] rd;
        int lat, d0, r0;
        mem_lat = 5;
        fill_line = '0;
        fill_line[127:64] = 64'hF1;
        d0 = done_cnt; r0 = rd_txn;
        enable = 1'b1; wenable = 1'b0; addr = 64'h3008;
        @(negedge clk);
        enable = 1'b0;
        vecs++; if (mreq !== 1'b1) begin errs++; $display("FAIL abort_mreq_up: got %b want 1", mreq); end
        #2 reset = 1'b1;
        #1;
        vecs++; if (mreq !== 1'b0) begin errs++; $display("FAIL abort_mreq_async: got %b want 0", mreq); end
        repeat (2) @(negedge clk);
        vecs++; if (done_cnt - d0 !== 0 || rd_txn - r0 !== 0) begin errs++; $display("FAIL abort_no_done: got %0d done %0d fills want 0 0", done_cnt - d0, rd_txn - r0); end
        mem_lat = 0;
        reset = 1'b0;
        do_req(1'b0, 64'h3008, 64'h0, rd, lat);
        vecs++; if (rd_txn - r0 !== 1 || last_maddr !== 64'h3000) begin errs++; $display("FAIL retry_fill: got %0d fills maddr %h want 1 3000", rd_txn - r0, last_maddr); end
        vecs++; if (lat !== 2 || rd !== 64'hF1) begin errs++; $display("FAIL retry_resp: got lat %0d data %h want 2 f1", lat, rd); end
        vecs++; if (done_cnt - d0 !== 1) begin errs++; $display("FAIL retry_done: got %0d pulses want 1", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_store_hit();
        test_conflict();
        test_mmio();
        test_store_miss();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/dline_cache.md
DLINE_CACHE -- requirements
Module: dline_cache

Interface
REQ-001 Parameter: LINES, default 8, number of direct-mapped 64-byte lines (power of two, >=2).
REQ-002 Port: clk  input  1  sole clock; all state updates on posedge.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears state immediately when asserted.
REQ-004 Port: enable  input  1  core request valid; sampled only in IDLE.
REQ-005 Port: wenable  input  1  1 = 64-bit store, 0 = 64-bit load; sampled with enable.
REQ-006 Port: addr  input  64  byte address; addr[2:0] ignored (8-byte word).
REQ-007 Port: wdata  input  64  store data; sampled with enable.
REQ-008 Port: rdata  output  64  load data; valid while done=1, then held until the next accepted request.
REQ-009 Port: done  output  1  one-cycle completion pulse per accepted request.
REQ-010 Port: mreq  output  1  line request to arbiter; held high until mdone.
REQ-011 Port: mwrenable  output  1  1 = line write, 0 = line read; stable while mreq=1.
REQ-012 Port: maddr  output  64  line address, maddr[5:0]=0; stable while mreq=1.
REQ-013 Port: mrdata  input  512  fill data, byte 0 at bits [7:0]; valid in the cycle mdone=1.
REQ-014 Port: mwdata  output  512  write-back line; stable while mreq=1.
REQ-015 Port: mdone  input  1  arbiter completion; ignored when mreq=0.

Function
REQ-016 Index = addr[6 +: log2(LINES)], tag = remaining upper bits, word = addr[5:3]; array holds valid, tag, 512-bit data per line.
REQ-017 States: IDLE, FILL, WRITE, RESP; no other states reachable.
REQ-018 IDLE: on enable=1, capture wenable/addr/wdata; load hit -> RESP; miss or MMIO -> FILL; store hit -> WRITE, with the word merged into the captured line.
REQ-019 MMIO range: 640*1024 < addr < 1024*1024 (strict); MMIO requests never look up, install or modify array contents.
REQ-020 FILL: mreq=1, mwrenable=0, maddr={addr[63:6],6'b0}; on mdone: non-MMIO installs mrdata (valid=1, new tag, victim overwritten, no write-back needed); load -> RESP, store -> WRITE.
REQ-021 WRITE (write-through, write-allocate): mreq=1, mwrenable=1, mwdata = line with word replaced by wdata; the cached copy is updated at the same time for non-MMIO; on mdone -> RESP.
REQ-022 RESP: done=1 for exactly one cycle, rdata = selected word (load) or wdata (store); next state IDLE.
REQ-023 Latency: load hit done at N+1 for enable at N; load miss done one cycle after mdone; store = fill (if miss) + write + 1 cycle.
REQ-024 The core must drop enable in the cycle after done; enable=1 seen in IDLE is always a new request.
REQ-025 enable changes outside IDLE are ignored; at most one request is outstanding.
REQ-026 mdone in the same cycle mreq first rises is accepted (zero-wait arbiter).
REQ-027 Replacement of the same index by a different tag evicts silently (write-through, no dirty data).

Reset
REQ-028 On reset: state=IDLE, all valid bits=0, done=0, mreq=0, mwrenable=0, maddr=0, mwdata=0, rdata=0.
REQ-029 Reset mid-FILL/WRITE: mreq drops asynchronously, no line is installed, and no done is produced for the aborted request.
REQ-030 The first request after reset deassertion is accepted in the first IDLE clock edge.

Verification
REQ-031 Cold load addr=0x1008: FILL maddr=0x1000, mrdata word1=0xAABB -> done, rdata=0x0000_0000_0000_AABB; repeat load -> done at N+1 with no mreq.
REQ-032 Store addr=0x1010 wdata=0x55 after REQ-031 fill: WRITE only (no fill), mwdata word2=0x55 and other words unchanged; subsequent load 0x1010 hits and returns 0x55.
REQ-033 LINES=8: load 0x1000 then 0x1200 (same index, new tag) -> second misses; reload 0x1000 misses again.
REQ-034 MMIO load addr=0xA0008: FILL issued, done returned, repeat load issues FILL again (not cached); addr=0xA0000 exactly is cached.
REQ-035 Assert reset during FILL with mreq=1 -> mreq=0 immediately, no done; retry same address -> fresh FILL.
REQ-036 Store miss addr=0x2000: FILL then WRITE, two mreq transactions (mwrenable 0 then 1), exactly one done pulse.
